// File: rtl/exec_muldiv_unit.sv
// exec_muldiv_unit: multi-cycle multiply/divide unit holding the HI/LO registers.
// Iterative shift-add multiply and restoring divide over WIDTH steps; signed ops
// run on magnitudes and are sign-corrected in a single FIX cycle.
// Optional: define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module exec_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    // acc_hi_q/acc_lo_q: product high/low halves, or remainder/quotient when dividing
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
    logic             neg_res_q, neg_rem_q, is_div_q, dbz_q;
    logic             busy_q, done_q, dbz_out_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_trial;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    // Operand signs/magnitudes of the incoming request (op[0]=0 means signed)
    always_comb begin
        a_neg = ~op[0] & src_a[WIDTH-1];
        b_neg = ~op[0] & src_b[WIDTH-1];
        a_mag = a_neg ? -src_a : src_a;
        b_mag = b_neg ? -src_b : src_b;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;

    // Single-cycle product; sign-extend only for signed ops
    always_comb begin
        fast_prod = {{WIDTH{a_neg}}, src_a} * {{WIDTH{b_neg}}, src_b};
    end
`endif

    // One iteration step of each algorithm plus the sign-corrected results
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + {1'b0, opnd_q & {WIDTH{acc_lo_q[0]}}};
        div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opnd_q};
        prod_mag  = {acc_hi_q, acc_lo_q};
        prod_fix  = neg_res_q ? -prod_mag : prod_mag;
        quot_fix  = neg_res_q ? -acc_lo_q : acc_lo_q;
        rem_fix   = neg_rem_q ? -acc_hi_q : acc_hi_q;
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (flush) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    state_q   <= StIdle;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    dbz_out_q <= 1'b0;
                    cnt_q     <= '0;
                    if (start) begin
                        case (op)
                            OpMult, OpMultu: begin
                                is_div_q <= 1'b0;
                                dbz_q    <= 1'b0;
                                busy_q   <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                                acc_hi_q  <= fast_prod[2*WIDTH-1:WIDTH];
                                acc_lo_q  <= fast_prod[WIDTH-1:0];
                                neg_res_q <= 1'b0;
                                state_q   <= StFix;
`else
                                acc_hi_q  <= '0;
                                acc_lo_q  <= b_mag;
                                opnd_q    <= a_mag;
                                neg_res_q <= a_neg ^ b_neg;
                                state_q   <= StMul;
`endif
                            end
                            OpDiv, OpDivu: begin
                                is_div_q  <= 1'b1;
                                busy_q    <= 1'b1;
                                neg_res_q <= a_neg ^ b_neg;
                                neg_rem_q <= a_neg;
                                if (src_b == '0) begin
                                    // No iterations: HI takes the raw dividend
                                    dbz_q    <= 1'b1;
                                    acc_hi_q <= src_a;
                                    state_q  <= StFix;
                                end else begin
                                    dbz_q    <= 1'b0;
                                    acc_hi_q <= '0;
                                    acc_lo_q <= a_mag;
                                    opnd_q   <= b_mag;
                                    state_q  <= StDiv;
                                end
                            end
                            OpMthi:  hi_q <= src_a;
                            OpMtlo:  lo_q <= src_a;
                            default: ;
                        endcase
                    end
                end
                StMul: begin
                    // WIDTH steps at cnt 0..WIDTH-1, then one hand-off cycle at cnt=WIDTH
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        cnt_q   <= '0;
                        state_q <= StFix;
                    end else begin
                        acc_hi_q <= mul_sum[WIDTH:1];
                        acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                        cnt_q    <= cnt_q + CNT_W'(1);
                    end
                end
                StDiv: begin
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        cnt_q   <= '0;
                        state_q <= StFix;
                    end else begin
                        if (!div_trial[WIDTH]) begin
                            acc_hi_q <= div_trial[WIDTH-1:0];
                            acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi_q <= {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
                            acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b0};
                        end
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StFix: begin
                    if (!is_div_q) begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else if (dbz_q) begin
                        hi_q <= acc_hi_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    dbz_out_q <= is_div_q & dbz_q;
                    state_q   <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Self-checking bench for exec_muldiv_unit (default build, WIDTH=32).
// Results are checked against a 64-bit arithmetic reference model.
module tb_exec_muldiv_unit;

    localparam int unsigned W = 32;
    localparam int unsigned LAT = W + 2;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int tests_run = 0;
    int fails = 0;

    exec_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clock = ~clock;

    // Reference: plain 64-bit arithmetic on the architectural definition
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
        longint sa, sb, sp;
        logic [63:0] up;
        z = 1'b0;
        h = '0;
        l = '0;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'd0: begin sp = sa * sb; up = sp; h = up[63:32]; l = up[31:0]; end
            3'd1: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    h = a; l = '1; z = 1'b1;
                end else if (o == 3'd2) begin
                    sp = sa / sb; l = sp[31:0];
                    sp = sa % sb; h = sp[31:0];
                end else begin
                    l = a / b; h = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Issue one op and follow it to completion; returns what was observed
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int nbusy, output logic d1, output logic z1,
                         output logic d2, output logic tmo);
        @(negedge clock);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0; src_a = $urandom; src_b = $urandom;
        nbusy = 0; tmo = 1'b0;
        while (busy === 1'b1 && !tmo) begin
            nbusy++;
            if (nbusy > 200) tmo = 1'b1;
            @(negedge clock);
        end
        d1 = done; z1 = div_by_zero;
        @(negedge clock);
        d2 = done;
    endtask

    task automatic test_reset();
        int nb; logic d1, z1, d2, tmo;
        #12;
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
        tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b want=0", done); end
        tests_run++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
        tests_run++; if (hi !== '0 || lo !== '0) begin fails++; $display("FAIL reset_hilo got=%h/%h want=0/0", hi, lo); end
        @(negedge clock); reset = 1'b1;
        @(negedge clock); start = 1'b1; op = 3'd4; src_a = 32'hDEAD_0001;
        @(negedge clock); op = 3'd5; src_a = 32'hBEEF_0002;
        @(negedge clock); op = 3'd2; src_a = 32'h7FFF_FFFF; src_b = 32'd3;
        @(negedge clock); start = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL middiv_reset_busy got=%b want=0", busy); end
        tests_run++; if (hi !== '0 || lo !== '0) begin fails++; $display("FAIL middiv_reset_hilo got=%h/%h want=0/0", hi, lo); end
        @(negedge clock); reset = 1'b1;
        issue(3'd3, 32'd100, 32'd7, nb, d1, z1, d2, tmo);
        tests_run++; if (lo !== 32'd14 || hi !== 32'd2) begin fails++; $display("FAIL divu_after_reset got=%h/%h want=2/14", hi, lo); end
        tests_run++; if (nb !== LAT || tmo) begin fails++; $display("FAIL divu_after_reset_lat got=%0d want=%0d", nb, LAT); end
    endtask

    task automatic test_mul();
        int nb; logic d1, z1, d2, tmo;
        issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, nb, d1, z1, d2, tmo);
        tests_run++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin fails++; $display("FAIL mult_neg got=%h/%h want=ffffffff/fffffffa", hi, lo); end
        tests_run++; if (nb !== LAT || tmo) begin fails++; $display("FAIL mult_lat got=%0d want=%0d", nb, LAT); end
        tests_run++; if (d1 !== 1'b1 || d2 !== 1'b0 || z1 !== 1'b0) begin fails++; $display("FAIL mult_done_pulse got=%b%b%b want=100", d1, d2, z1); end
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, d1, z1, d2, tmo);
        tests_run++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin fails++; $display("FAIL multu_max got=%h/%h want=fffffffe/00000001", hi, lo); end
    endtask

    task automatic test_div();
        int nb; logic d1, z1, d2, tmo;
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, nb, d1, z1, d2, tmo);
        tests_run++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_neg got=%h/%h want=ffffffff/fffffffd", hi, lo); end
        tests_run++; if (nb !== LAT || d1 !== 1'b1 || z1 !== 1'b0) begin fails++; $display("FAIL div_neg_lat got=%0d,%b,%b want=%0d,1,0", nb, d1, z1, LAT); end
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb, d1, z1, d2, tmo);
        tests_run++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin fails++; $display("FAIL div_ovf got=%h/%h want=0/80000000", hi, lo); end
        tests_run++; if (z1 !== 1'b0) begin fails++; $display("FAIL div_ovf_flag got=%b want=0", z1); end
    endtask

    task automatic test_div_zero();
        int nb; logic d1, z1, d2, tmo;
        issue(3'd3, 32'h0000_1234, 32'd0, nb, d1, z1, d2, tmo);
        tests_run++; if (nb !== 1 || tmo) begin fails++; $display("FAIL dbz_lat got=%0d want=1", nb); end
        tests_run++; if (hi !== 32'h0000_1234 || lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL dbz_hilo got=%h/%h want=00001234/ffffffff", hi, lo); end
        tests_run++; if (d1 !== 1'b1 || z1 !== 1'b1) begin fails++; $display("FAIL dbz_pulse got=%b%b want=11", d1, z1); end
        tests_run++; if (d2 !== 1'b0 || div_by_zero !== 1'b0) begin fails++; $display("FAIL dbz_pulse_end got=%b%b want=00", d2, div_by_zero); end
    endtask

    task automatic test_flush();
        logic [W-1:0] h0, l0;
        int seen;
        h0 = hi; l0 = lo;
        @(negedge clock); op = 3'd1; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (4) @(negedge clock);
        flush = 1'b1; start = 1'b1; op = 3'd4; src_a = 32'hCAFE_F00D;
        @(negedge clock); flush = 1'b0; start = 1'b0;
        tests_run++; if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin fails++; $display("FAIL flush_ctl got=%b%b%b want=000", busy, done, div_by_zero); end
        tests_run++; if (hi !== h0 || lo !== l0) begin fails++; $display("FAIL flush_hilo got=%h/%h want=%h/%h", hi, lo, h0, l0); end
        seen = 0;
        repeat (40) begin @(negedge clock); if (done === 1'b1 || busy === 1'b1) seen++; end
        tests_run++; if (seen !== 0) begin fails++; $display("FAIL flush_quiet got=%0d want=0", seen); end
    endtask

    task automatic test_mt_back_to_back();
        @(negedge clock); start = 1'b1; op = 3'd4; src_a = 32'hA5A5_A5A5;
        @(negedge clock); op = 3'd5; src_a = 32'h5A5A_5A5A;
        tests_run++; if (hi !== 32'hA5A5_A5A5 || busy !== 1'b0) begin fails++; $display("FAIL mthi got=%h,%b want=a5a5a5a5,0", hi, busy); end
        @(negedge clock); start = 1'b0;
        tests_run++; if (lo !== 32'h5A5A_5A5A || hi !== 32'hA5A5_A5A5 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mtlo got=%h/%h,%b%b want=a5a5a5a5/5a5a5a5a,00", hi, lo, busy, done); end
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] a, b, eh, el; logic ez;
        int nb;
        a = $urandom; b = $urandom_range(1, 1000);
        model(3'd2, a, b, eh, el, ez);
        @(negedge clock); op = 3'd2; src_a = a; src_b = b; start = 1'b1;
        @(negedge clock); nb = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            start = (nb < 30); op = nb[0] ? 3'd4 : 3'd3; src_a = $urandom; src_b = $urandom;
            @(negedge clock);
        end
        start = 1'b0;
        tests_run++; if (hi !== eh || lo !== el || nb !== LAT) begin fails++; $display("FAIL busy_ignore got=%h/%h,%0d want=%h/%h,%0d", hi, lo, nb, eh, el, LAT); end
        @(negedge clock);
        tests_run++; if (busy !== 1'b0 || hi !== eh) begin fails++; $display("FAIL busy_not_queued got=%b,%h want=0,%h", busy, hi, eh); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] eh, el, eh2, el2; logic ez;
        int nb;
        model(3'd1, 32'h0001_0003, 32'h0002_0005, eh, el, ez);
        model(3'd3, 32'hF000_0000, 32'd9, eh2, el2, ez);
        @(negedge clock); op = 3'd1; src_a = 32'h0001_0003; src_b = 32'h0002_0005; start = 1'b1;
        @(negedge clock); start = 1'b0; nb = 0;
        while (done !== 1'b1 && nb < 200) begin nb++; @(negedge clock); end
        op = 3'd3; src_a = 32'hF000_0000; src_b = 32'd9; start = 1'b1;
        tests_run++; if (hi !== eh || lo !== el) begin fails++; $display("FAIL b2b_first got=%h/%h want=%h/%h", hi, lo, eh, el); end
        @(negedge clock); start = 1'b0;
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept got=%b want=1", busy); end
        nb = 0;
        while (done !== 1'b1 && nb < 200) begin nb++; @(negedge clock); end
        tests_run++; if (hi !== eh2 || lo !== el2 || nb !== LAT) begin fails++; $display("FAIL b2b_second got=%h/%h,%0d want=%h/%h,%0d", hi, lo, nb, eh2, el2, LAT); end
    endtask

    task automatic test_random();
        int nb; logic d1, z1, d2, tmo;
        logic [2:0] o; logic [W-1:0] a, b, eh, el; logic ez;
        int elat;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            model(o, a, b, eh, el, ez);
            elat = ez ? 1 : LAT;
            issue(o, a, b, nb, d1, z1, d2, tmo);
            tests_run++; if (hi !== eh || lo !== el) begin fails++; $display("FAIL rand_%0d op=%0d a=%h b=%h got=%h/%h want=%h/%h", i, o, a, b, hi, lo, eh, el); end
            tests_run++; if (nb !== elat || tmo || d1 !== 1'b1 || z1 !== ez || d2 !== 1'b0) begin fails++; $display("FAIL rand_ctl_%0d got=%0d,%b%b%b want=%0d,1%b0", i, nb, d1, z1, d2, elat, ez); end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_flush();
        test_mt_back_to_back();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
